// File: rtl/uart_frame_parser_pkg.sv
// Shared constants and types for the UART command-frame parser.
// Holds the sync bytes, frame geometry, FSM encoding and function codes.
package uart_frame_parser_pkg;

    localparam logic [7:0]  DEF_HDR0        = 8'hA5;
    localparam logic [7:0]  DEF_HDR1        = 8'h5A;
    localparam int unsigned N_DATA          = 11;
    localparam int unsigned IDX_W           = $clog2(N_DATA);
    localparam int unsigned DEF_TIMEOUT_CYC = 50000;

    localparam logic [7:0]  FUNC_HS_PWM     = 8'h01;
    localparam logic [7:0]  FUNC_LS_PWM     = 8'h02;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_HDR1 = 3'd1,
        ST_FUNC = 3'd2,
        ST_DATA = 3'd3,
        ST_CSUM = 3'd4
    } state_t;

    function automatic logic func_is_known(input logic [7:0] f);
        return (f == FUNC_HS_PWM) || (f == FUNC_LS_PWM);
    endfunction

endpackage

// File: rtl/uart_frame_parser_if.sv
// Byte-in / frame-out bundle between uart_rx, the frame parser and uart_reg_mapper.
// rx_data is qualified by the one-cycle rx_done strobe; no backpressure exists, every strobe is a byte.
interface uart_frame_parser_if;

    logic [7:0] rx_data;
    logic       rx_done;
    logic [7:0] func_reg;
    logic [7:0] rev_data1;
    logic [7:0] rev_data2;
    logic [7:0] rev_data3;
    logic [7:0] rev_data4;
    logic [7:0] rev_data5;
    logic [7:0] rev_data6;
    logic [7:0] rev_data7;
    logic [7:0] rev_data8;
    logic [7:0] rev_data9;
    logic [7:0] rev_data10;
    logic [7:0] rev_data11;
    logic       pack_done;
    logic       csum_err;
    logic       timeout_err;

    modport master (
        output rx_data, rx_done,
        input  func_reg, rev_data1, rev_data2, rev_data3, rev_data4, rev_data5,
               rev_data6, rev_data7, rev_data8, rev_data9, rev_data10, rev_data11,
               pack_done, csum_err, timeout_err
    );

    modport slave (
        input  rx_data, rx_done,
        output func_reg, rev_data1, rev_data2, rev_data3, rev_data4, rev_data5,
               rev_data6, rev_data7, rev_data8, rev_data9, rev_data10, rev_data11,
               pack_done, csum_err, timeout_err
    );

endinterface

// File: rtl/uart_frame_parser_gap_timer.sv
// Inter-byte gap timer: counts while a frame is open, restarts on every byte,
// and flags expiry on the LIMIT-th idle cycle unless a byte arrives that same cycle.
module uart_frame_parser_gap_timer #(
    parameter int unsigned LIMIT = 50000
) (
    input  logic clk_50M,
    input  logic rst_n,
    input  logic i_run,
    input  logic i_clear,
    output logic o_expire
);

    localparam int unsigned CW = $clog2(LIMIT);

    logic [CW-1:0] r_cnt;
    logic          w_at_limit;

    assign w_at_limit = (r_cnt == CW'(LIMIT - 1));
    assign o_expire   = i_run && !i_clear && w_at_limit;

    always_ff @(posedge clk_50M or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (!i_run || i_clear || w_at_limit) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/uart_frame_parser.sv
// Assembles A5 5A | func | 11 data | checksum frames from uart_rx bytes and
// publishes func/payload with a one-cycle pack_done only when the checksum matches.
module uart_frame_parser
    import uart_frame_parser_pkg::*;
#(
    parameter logic [7:0]  HDR0        = DEF_HDR0,
    parameter logic [7:0]  HDR1        = DEF_HDR1,
    parameter int unsigned TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
    input  logic                clk_50M,
    input  logic                rst_n,
    uart_frame_parser_if.slave  if_frame,
    output state_t              o_dbg_state
);

    state_t           r_state;
    state_t           w_next;
    logic [IDX_W-1:0] r_idx;
    logic [7:0]       r_sum;
    logic [7:0]       r_func_sh;
    logic [7:0]       r_shadow [N_DATA];
    logic [7:0]       r_func;
    logic [7:0]       r_rev [N_DATA];
    logic             r_pack_done;
    logic             r_csum_err;
    logic             r_timeout_err;

    logic             w_byte;
    logic             w_run;
    logic             w_expire;
    logic             w_last_data;
    logic             w_load_func;
    logic             w_load_data;
    logic             w_publish;
    logic             w_reject;

    assign w_byte      = if_frame.rx_done;
    assign w_run       = (r_state != ST_IDLE);
    assign w_last_data = (r_idx == IDX_W'(N_DATA - 1));
    assign o_dbg_state = r_state;

    uart_frame_parser_gap_timer #(
        .LIMIT (TIMEOUT_CYC)
    ) u_frame_gap_timer (
        .clk_50M  (clk_50M),
        .rst_n    (rst_n),
        .i_run    (w_run),
        .i_clear  (w_byte),
        .o_expire (w_expire)
    );

    always_ff @(posedge clk_50M or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Expiry is already masked by a same-cycle byte inside the timer.
    always_comb begin
        w_next = r_state;
        if (w_expire) begin
            w_next = ST_IDLE;
        end else if (w_byte) begin
            case (r_state)
                ST_IDLE: if (if_frame.rx_data == HDR0) w_next = ST_HDR1;
                ST_HDR1: begin
                    if (if_frame.rx_data == HDR1)      w_next = ST_FUNC;
                    else if (if_frame.rx_data == HDR0) w_next = ST_HDR1;
                    else                               w_next = ST_IDLE;
                end
                ST_FUNC: w_next = ST_DATA;
                ST_DATA: if (w_last_data) w_next = ST_CSUM;
                ST_CSUM: w_next = ST_IDLE;
                default: w_next = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        w_load_func = 1'b0;
        w_load_data = 1'b0;
        w_publish   = 1'b0;
        w_reject    = 1'b0;
        if (w_byte) begin
            case (r_state)
                ST_FUNC: w_load_func = 1'b1;
                ST_DATA: w_load_data = 1'b1;
                ST_CSUM: begin
                    if (if_frame.rx_data == r_sum) w_publish = 1'b1;
                    else                           w_reject  = 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Shadow buffer fills in the background so a bad frame never disturbs the outputs.
    always_ff @(posedge clk_50M or negedge rst_n) begin
        if (!rst_n) begin
            r_idx     <= '0;
            r_sum     <= '0;
            r_func_sh <= '0;
            for (int i = 0; i < N_DATA; i++) r_shadow[i] <= '0;
        end else if (w_load_func) begin
            r_func_sh <= if_frame.rx_data;
            r_sum     <= if_frame.rx_data;
            r_idx     <= '0;
        end else if (w_load_data) begin
            r_shadow[r_idx] <= if_frame.rx_data;
            r_sum           <= r_sum + if_frame.rx_data;
            r_idx           <= r_idx + 1'b1;
        end
    end

    always_ff @(posedge clk_50M or negedge rst_n) begin
        if (!rst_n) begin
            r_func        <= '0;
            for (int i = 0; i < N_DATA; i++) r_rev[i] <= '0;
            r_pack_done   <= 1'b0;
            r_csum_err    <= 1'b0;
            r_timeout_err <= 1'b0;
        end else begin
            r_pack_done   <= w_publish;
            r_csum_err    <= w_reject;
            r_timeout_err <= w_expire;
            if (w_publish) begin
                r_func <= r_func_sh;
                for (int i = 0; i < N_DATA; i++) r_rev[i] <= r_shadow[i];
            end
        end
    end

    assign if_frame.func_reg    = r_func;
    assign if_frame.rev_data1   = r_rev[0];
    assign if_frame.rev_data2   = r_rev[1];
    assign if_frame.rev_data3   = r_rev[2];
    assign if_frame.rev_data4   = r_rev[3];
    assign if_frame.rev_data5   = r_rev[4];
    assign if_frame.rev_data6   = r_rev[5];
    assign if_frame.rev_data7   = r_rev[6];
    assign if_frame.rev_data8   = r_rev[7];
    assign if_frame.rev_data9   = r_rev[8];
    assign if_frame.rev_data10  = r_rev[9];
    assign if_frame.rev_data11  = r_rev[10];
    assign if_frame.pack_done   = r_pack_done;
    assign if_frame.csum_err    = r_csum_err;
    assign if_frame.timeout_err = r_timeout_err;

endmodule

// File: tb/tb_uart_frame_parser.sv
// Directed bench for uart_frame_parser: frame vectors from a table plus
// timeout, expiry-edge and mid-frame reset sequences.
module tb_uart_frame_parser;
  import uart_frame_parser_pkg::*;

  localparam int unsigned T_CYC = 1000;

  localparam logic [95:0] OUT_A = 96'h01_00_01_10_00_64_05_00_00_00_FF_00;
  localparam logic [95:0] OUT_B = 96'h02_11_22_33_44_55_66_77_88_99_AA_BB;
  localparam logic [95:0] OUT_C = 96'h01_A5_5A_A5_00_00_00_00_00_00_00_01;
  localparam logic [95:0] OUT_D = 96'hFF_FF_FF_FF_FF_FF_FF_FF_FF_FF_FF_FF;

  typedef struct {
    int              pre_len;
    logic [0:3][7:0] pre;
    logic [7:0]      func;
    logic [0:10][7:0] data;
    logic [7:0]      csum;
    logic            exp_pack;
    logic            exp_cerr;
    logic [95:0]     exp_out;
  } vec_t;

  // clock / reset
  logic clk_50M = 1'b0;
  logic rst_n   = 1'b0;
  always #10 clk_50M = ~clk_50M;

  uart_frame_parser_if bus();
  state_t dbg_state;

  uart_frame_parser #(
    .HDR0        (8'hA5),
    .HDR1        (8'h5A),
    .TIMEOUT_CYC (T_CYC)
  ) dut (
    .clk_50M     (clk_50M),
    .rst_n       (rst_n),
    .if_frame    (bus),
    .o_dbg_state (dbg_state)
  );

  int checks      = 0;
  int failures    = 0;
  int tout_pulses = 0;
  logic [95:0] exp_q[$];
  vec_t vecs[6];

  always @(negedge clk_50M) if (bus.timeout_err) tout_pulses++;

  // scoreboard helpers
  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [95:0] get_outs();
    return {bus.func_reg, bus.rev_data1, bus.rev_data2, bus.rev_data3, bus.rev_data4,
            bus.rev_data5, bus.rev_data6, bus.rev_data7, bus.rev_data8, bus.rev_data9,
            bus.rev_data10, bus.rev_data11};
  endfunction

  function automatic int frame_len(input vec_t v);
    return v.pre_len + 15;
  endfunction

  function automatic logic [7:0] frame_byte(input vec_t v, input int k);
    int j;
    j = k - v.pre_len;
    if (k < v.pre_len) return v.pre[k];
    if (j == 0) return 8'hA5;
    if (j == 1) return 8'h5A;
    if (j == 2) return v.func;
    if (j <= 13) return v.data[j-3];
    return v.csum;
  endfunction

  // driver tasks
  task automatic send_byte(input logic [7:0] b);
    @(negedge clk_50M);
    bus.rx_data = b;
    bus.rx_done = 1'b1;
    @(negedge clk_50M);
    bus.rx_done = 1'b0;
  endtask

  task automatic send_range(input vec_t v, input int from, input int to);
    for (int k = from; k <= to; k++) send_byte(frame_byte(v, k));
  endtask

  task automatic check_frame_end(input string tag, input logic ep, input logic ec,
                                 input logic [95:0] eo);
    chk({tag, "_pack"}, bus.pack_done, ep);
    chk({tag, "_cerr"}, bus.csum_err, ec);
    chk({tag, "_tout"}, bus.timeout_err, 1'b0);
    @(negedge clk_50M);
    chk({tag, "_pulse_end"}, {bus.pack_done, bus.csum_err}, 2'b00);
    chk({tag, "_outs"}, get_outs(), eo);
    chk({tag, "_state"}, dbg_state, ST_IDLE);
  endtask

  initial begin
    int gap_hits;
    int base;

    vecs[0] = '{0, 32'h0, 8'h01, 88'h00_01_10_00_64_05_00_00_00_FF_00, 8'h7A, 1'b1, 1'b0, OUT_A};
    vecs[1] = '{0, 32'h0, 8'h01, 88'h00_01_10_00_64_05_00_00_00_FF_00, 8'h7B, 1'b0, 1'b1, OUT_A};
    vecs[2] = '{1, 32'hA5_00_00_00, 8'h02, 88'h11_22_33_44_55_66_77_88_99_AA_BB, 8'h64,
                1'b1, 1'b0, OUT_B};
    vecs[3] = '{3, 32'h00_A5_33_00, 8'h01, 88'hA5_5A_A5_00_00_00_00_00_00_00_01, 8'hA6,
                1'b1, 1'b0, OUT_C};
    vecs[4] = '{0, 32'h0, 8'h02, 88'h0, 8'h03, 1'b0, 1'b1, OUT_C};
    vecs[5] = '{0, 32'h0, 8'hFF, {11{8'hFF}}, 8'hF4, 1'b1, 1'b0, OUT_D};

    bus.rx_data = 8'h00;
    bus.rx_done = 1'b0;
    repeat (3) @(negedge clk_50M);
    chk("reset_outs_held", get_outs(), 96'h0);
    rst_n = 1'b1;
    @(negedge clk_50M);
    chk("reset_outs", get_outs(), 96'h0);
    chk("reset_pulses", {bus.pack_done, bus.csum_err, bus.timeout_err}, 3'b000);
    chk("reset_state", dbg_state, ST_IDLE);

    for (int i = 0; i < 6; i++) begin
      send_range(vecs[i], 0, frame_len(vecs[i]) - 1);
      exp_q.push_back(vecs[i].exp_out);
      check_frame_end($sformatf("vec%0d", i), vecs[i].exp_pack, vecs[i].exp_cerr,
                      exp_q.pop_front());
    end

    // Stall after six bytes: expect exactly one timeout pulse on the T_CYC-th idle cycle.
    send_range(vecs[0], 0, 5);
    gap_hits = 0;
    repeat (T_CYC - 1) begin
      @(negedge clk_50M);
      if (bus.timeout_err) gap_hits++;
    end
    chk("tout_early", gap_hits, 0);
    @(negedge clk_50M);
    chk("tout_pulse", bus.timeout_err, 1'b1);
    chk("tout_state", dbg_state, ST_IDLE);
    @(negedge clk_50M);
    chk("tout_one_cycle", bus.timeout_err, 1'b0);
    chk("tout_outs_kept", get_outs(), OUT_D);
    send_range(vecs[0], 0, frame_len(vecs[0]) - 1);
    check_frame_end("after_tout", 1'b1, 1'b0, OUT_A);

    // Byte lands on the exact expiry cycle: it wins, the frame completes.
    base = tout_pulses;
    send_range(vecs[2], 0, 5);
    repeat (T_CYC - 2) @(negedge clk_50M);
    send_range(vecs[2], 6, frame_len(vecs[2]) - 1);
    check_frame_end("edge", 1'b1, 1'b0, OUT_B);
    chk("edge_no_tout", tout_pulses - base, 0);

    // Reset in the middle of the payload.
    send_range(vecs[0], 0, 4);
    chk("mid_state_data", dbg_state, ST_DATA);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_outs", get_outs(), 96'h0);
    chk("mid_rst_pulses", {bus.pack_done, bus.csum_err, bus.timeout_err}, 3'b000);
    chk("mid_rst_state", dbg_state, ST_IDLE);
    @(negedge clk_50M);
    rst_n = 1'b1;
    send_range(vecs[3], 0, frame_len(vecs[3]) - 1);
    check_frame_end("post_rst", 1'b1, 1'b0, OUT_C);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
